muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Core-side request/response bundle for the iterative multiply/divide unit.
// The core drives start/operands (master); the unit returns status and write-back (slave).
interface muldiv_unit_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] rs1_data;
  logic [N-1:0] rs2_data;
  logic [4:0]   rd_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [4:0]   rd_out;
  logic         wr_en;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out, wr_en
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out, wr_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 CALC cycles then a 1-cycle DONE; div-by-zero/overflow skip CALC.
// No backpressure: start is sampled only in IDLE, busy stalls the core, no request queuing.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] INT_MIN  = {1'b1, {(N-1){1'b0}}};

  logic [1:0]   state;
  logic [4:0]   cnt;
  logic [2:0]   op;
  logic [4:0]   rd_q;
  logic         neg;
  logic [N-1:0] hi, lo, b;
  logic [N-1:0] result_q;
  logic [4:0]   rd_out_q;

  // Operand decode at capture time
  logic         a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, neg_in;
  logic [N-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (bus.funct3 != 3'd3) && (bus.funct3 != 3'd5) && (bus.funct3 != 3'd7);
    b_signed = (bus.funct3 == 3'd0) || (bus.funct3 == 3'd1) ||
               (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    a_neg    = a_signed && bus.rs1_data[N-1];
    b_neg    = b_signed && bus.rs2_data[N-1];
    a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
    div_zero = bus.funct3[2] && (bus.rs2_data == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.rs1_data == INT_MIN) && (bus.rs2_data == ALL_ONES);
    // Remainder takes the dividend's sign; everything else takes sign A xor sign B
    neg_in   = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration step plus final sign fix-up of the post-step values
  logic [N:0]     mul_sum, div_sh, div_diff;
  logic [N-1:0]   nhi, nlo, q_s, r_s, final_res;
  logic [2*N-1:0] prod, prod_s;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    div_sh   = {hi, lo[N-1]};
    div_diff = div_sh - {1'b0, b};
    nhi      = mul_sum[N:1];
    nlo      = {mul_sum[0], lo[N-1:1]};
    if (op[2]) begin
      if (!div_diff[N]) begin
        nhi = div_diff[N-1:0];
        nlo = {lo[N-2:0], 1'b1};
      end else begin
        nhi = div_sh[N-1:0];
        nlo = {lo[N-2:0], 1'b0};
      end
    end
    prod   = {nhi, nlo};
    prod_s = neg ? -prod : prod;
    q_s    = neg ? -nlo : nlo;
    r_s    = neg ? -nhi : nhi;
    if (op[2])
      final_res = op[1] ? r_s : q_s;
    else
      final_res = (op == 3'd0) ? prod_s[N-1:0] : prod_s[2*N-1:N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      rd_q     <= '0;
      neg      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      b        <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op   <= bus.funct3;
            rd_q <= bus.rd_in;
            neg  <= neg_in;
            hi   <= '0;
            lo   <= bus.funct3[2] ? a_mag : b_mag;
            b    <= bus.funct3[2] ? b_mag : a_mag;
            cnt  <= '0;
            if (div_zero) begin
              result_q <= bus.funct3[1] ? bus.rs1_data : ALL_ONES;
              rd_out_q <= bus.rd_in;
              state    <= DONE;
            end else if (div_ovf) begin
              result_q <= bus.funct3[1] ? '0 : INT_MIN;
              rd_out_q <= bus.rd_in;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= nhi;
          lo  <= nlo;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result_q <= final_res;
            rd_out_q <= rd_q;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.wr_en  = (state == DONE) && (rd_out_q != 5'd0);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, special cases, reset abort, back-to-back.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  muldiv_unit_if #(.N(32)) bus ();

  muldiv_unit #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request, scrambles inputs after capture, waits (bounded) for done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] bv,
                        input logic [4:0] rd, output int lat, output int bcnt,
                        output logic [31:0] res, output logic [4:0] rdo, output logic wr);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = bv; bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0; bus.funct3 = ~f; bus.rs1_data = ~a; bus.rs2_data = 32'h0000_1234;
    bus.rd_in = ~rd;
    lat = -1; bcnt = 0; res = '0; rdo = '0; wr = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = c; res = bus.result; rdo = bus.rd_out; wr = bus.wr_en;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out: got %0d want 0", bus.rd_out); end
    // start asserted during reset must be dropped
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd2; bus.rs2_data = 32'd3; bus.rd_in = 5'd1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy %b want 0", bus.busy); end
  endtask

  task automatic test_mul();
    int lat, bcnt; logic [31:0] res; logic [4:0] rdo; logic wr;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, bcnt, res, rdo, wr);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++; if (bcnt !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", bcnt); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd_out: got %0d want 5", rdo); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL mul_wr_en: got %b want 1", wr); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL mul_wr_pulse: got %b want 0", bus.wr_en); end
    checks++; if (bus.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h want ffffffeb", bus.result); end
  endtask

  task automatic test_mulh();
    int lat, bcnt; logic [31:0] res; logic [4:0] rdo; logic wr;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result: got %h want fffffffe", res); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL mulh_result: got %h want 00000000", res); end
    // -1 * (2^32-1) = 0xFFFFFFFF_00000001
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result: got %h want ffffffff", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulhsu_latency: got %0d want 33", lat); end
  endtask

  task automatic test_div();
    int lat, bcnt; logic [31:0] res; logic [4:0] rdo; logic wr;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result: got %h want fffffffd", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_result: got %h want ffffffff", res); end
    run_op(3'd5, 32'd100, 32'd7, 5'd11, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result: got %0d want 14", res); end
    run_op(3'd7, 32'd100, 32'd7, 5'd12, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_result: got %0d want 2", res); end
    checks++; if (rdo !== 5'd12) begin errors++; $display("FAIL remu_rd_out: got %0d want 12", rdo); end
  endtask

  task automatic test_div_special();
    int lat, bcnt; logic [31:0] res; logic [4:0] rdo; logic wr;
    run_op(3'd5, 32'd5, 32'd0, 5'd13, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_result: got %h want ffffffff", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL divu0_latency: got %0d want 1", lat); end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL divu0_busy: got %0d want 0", bcnt); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL divu0_wr_en: got %b want 1", wr); end
    run_op(3'd7, 32'd5, 32'd0, 5'd14, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu0_result: got %h want 5", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL remu0_latency: got %0d want 1", lat); end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL remu0_busy: got %0d want 0", bcnt); end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_result: got %h want 80000000", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf_result: got %h want 0", res); end
  endtask

  task automatic test_rd_zero();
    int lat, bcnt; logic [31:0] res; logic [4:0] rdo; logic wr;
    run_op(3'd0, 32'd9, 32'd9, 5'd0, lat, bcnt, res, rdo, wr);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rd0_done: latency %0d want 33", lat); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rd0_wr_en: got %b want 0", wr); end
    checks++; if (res !== 32'd81) begin errors++; $display("FAIL rd0_result: got %0d want 81", res); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4; bus.rd_in = 5'd1;
    n = 0;
    // start stays high through CALC; a restart would stretch the latency
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    checks++; if (n !== 33) begin errors++; $display("FAIL held_start_latency: got %0d want 33", n); end
    checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL held_start_result: got %0d want 12", bus.result); end
    bus.funct3 = 3'd5; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_in = 5'd2;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b done %b want 0 0", bus.busy, bus.done); end
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk); n++;
      if (n == 1) bus.start = 1'b0;
    end
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", n); end
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL b2b_result: got %0d want 14", bus.result); end
    checks++; if (bus.rd_out !== 5'd2) begin errors++; $display("FAIL b2b_rd_out: got %0d want 2", bus.rd_out); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone; logic [31:0] res; logic [4:0] rdo; logic wr;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5; bus.rd_in = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    // first CALC cycle is iteration 0; advance to iteration 10
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL mid_rst_result: got %h want 0", bus.result); end
    checks++; if (bus.rd_out !== 5'd0) begin errors++; $display("FAIL mid_rst_rd_out: got %0d want 0", bus.rd_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.wr_en) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_no_done: got %0d done cycles want 0", ndone); end
    run_op(3'd0, 32'd6, 32'd7, 5'd3, lat, bcnt, res, rdo, wr);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL post_rst_result: got %0d want 42", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL post_rst_latency: got %0d want 33", lat); end
    checks++; if (rdo !== 5'd3 || wr !== 1'b1) begin errors++; $display("FAIL post_rst_wb: rd %0d wr %b want 3 1", rdo, wr); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_mul();
    test_reset();
    test_mulh();
    test_div();
    test_div_special();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
